irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 17 +
 rtl/irq_sync.sv | 22 ++
 rtl/irq_ctrl.sv | 156 +++++++++++++++
 tb/tb_irq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt controller:
// register offsets, port FSM state encoding and interrupt ID width.
package irq_ctrl_pkg;

   localparam int unsigned ID_W = 5;

   localparam logic [11:0] OFF_PENDING = 12'h000;
   localparam logic [11:0] OFF_ENABLE  = 12'h004;
   localparam logic [11:0] OFF_CLAIM   = 12'h008;
   localparam logic [11:0] OFF_RAW     = 12'h00C;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } port_state_t;

endpackage

// File: rtl/irq_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain bringing an asynchronous
// interrupt line into the clk domain.
module irq_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the raw line through the chain; the oldest stage is the output.
   always_ff @(posedge clk) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source synchronizers, pending/enable registers,
// fixed-priority (lowest index wins) ID encoding with a claim register, and a
// two-state request/response register port.
// Optional build macro IRQ_CTRL_LEVEL_EN: pending bits follow the synchronized
// lines directly (level mode); W1C and CLAIM then do not clear anything.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [11:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   input  logic             resp_ready,
   output logic             cpu_irq,
   output logic [ID_W-1:0]  irq_id
);

   localparam logic [9:0] W_PENDING = OFF_PENDING[11:2];
   localparam logic [9:0] W_ENABLE  = OFF_ENABLE[11:2];
   localparam logic [9:0] W_CLAIM   = OFF_CLAIM[11:2];
   localparam logic [9:0] W_RAW     = OFF_RAW[11:2];

   port_state_t      state;
   logic [N_SRC-1:0] sync;
   logic [N_SRC-1:0] enable;
   logic [N_SRC-1:0] pend;
   logic [N_SRC-1:0] active;
   logic [N_SRC-1:0] claim_hot;
   logic [N_SRC-1:0] w1c_clr;
   logic [N_SRC-1:0] claim_clr;
   logic [ID_W-1:0]  id;
   logic [31:0]      rd_data;
   logic [9:0]       word;
   logic             accept;
   logic             wr_en;
   logic             rd_en;
   logic             unused_bits;

   for (genvar g = 0; g < N_SRC; g++) begin : g_sync
      irq_sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk (clk),
         .rst (rst),
         .d   (irq_src[g]),
         .q   (sync[g])
      );
   end

   assign word        = req_addr[11:2];
   assign accept      = (state == ST_IDLE) && req_valid;
   assign wr_en       = accept && req_write;
   assign rd_en       = accept && !req_write;
   assign active      = pend & enable;
   assign cpu_irq     = |active;
   assign irq_id      = id;
   assign unused_bits = ^{req_addr[1:0], req_wdata[31:N_SRC]};

   // Fixed priority: the lowest active index gives the ID and the claim mask.
   always_comb begin
      id        = '0;
      claim_hot = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (active[i] && (claim_hot == '0)) begin
            id           = ID_W'(i + 1);
            claim_hot[i] = 1'b1;
         end
      end
   end

   // Read data mux, evaluated at acceptance; writes and unmapped offsets give 0.
   always_comb begin
      rd_data = '0;
      if (!req_write) begin
         case (word)
            W_PENDING: rd_data = 32'(pend);
            W_ENABLE:  rd_data = 32'(enable);
            W_CLAIM:   rd_data = 32'(id);
            W_RAW:     rd_data = 32'(sync);
            default:   rd_data = '0;
         endcase
      end
   end

   assign w1c_clr   = (wr_en && (word == W_PENDING)) ? req_wdata[N_SRC-1:0] : '0;
   assign claim_clr = (rd_en && (word == W_CLAIM))   ? claim_hot            : '0;

   // Enable register.
   always_ff @(posedge clk) begin
      if (rst)                            enable <= '0;
      else if (wr_en && word == W_ENABLE) enable <= req_wdata[N_SRC-1:0];
   end

`ifdef IRQ_CTRL_LEVEL_EN
   logic unused_level;
   assign unused_level = ^{w1c_clr, claim_clr};

   // Level mode: pending mirrors the synchronized lines.
   always_ff @(posedge clk) begin
      if (rst) pend <= '0;
      else     pend <= sync;
   end
`else
   logic [N_SRC-1:0] sync_d;
   logic [N_SRC-1:0] rise;
   assign rise = sync & ~sync_d;

   // Edge mode: set on rising sync, clear by W1C or CLAIM; a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_d <= '0;
         pend   <= '0;
      end else begin
         sync_d <= sync;
         pend   <= (pend & ~(w1c_clr | claim_clr)) | rise;
      end
   end
`endif

   // Register port FSM with registered handshake outputs and held response data.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  state      <= ST_RESP;
                  req_ready  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_rdata <= rd_data;
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  state      <= ST_IDLE;
                  req_ready  <= 1'b1;
                  resp_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (N_SRC=4, SYNC_STAGES=2).
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  irq_src = '0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [11:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_ready = 1'b0;
   logic        cpu_irq;
   logic [4:0]  irq_id;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   irq_ctrl #(.N_SRC(4), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irq_src),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_ready (resp_ready),
      .cpu_irq    (cpu_irq),
      .irq_id     (irq_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete access: accept, response one cycle later, consume.
   task automatic bus(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                      output logic [31:0] rd);
      @(negedge clk);
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      check("resp_valid_lat", 32'(resp_valid), 32'd1);
      rd = resp_rdata;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] wd);
      logic [31:0] rd;
      bus(1'b1, a, wd, rd);
      check("write_ack_data", rd, 32'd0);
   endtask

   task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      bus(1'b0, a, 32'd0, rd);
      check(tag, rd, exp);
   endtask

   initial begin
      // Reset
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_cpu_irq", 32'(cpu_irq), 32'd0);
      check("rst_irq_id", 32'(irq_id), 32'd0);
      rst = 1'b0;

`ifdef IRQ_CTRL_LEVEL_EN
      wr(12'h004, 32'h2);
      irq_src = 4'b0010;
      repeat (3) @(negedge clk);
      check("lvl_irq_on", 32'(cpu_irq), 32'd1);
      check("lvl_id", 32'(irq_id), 32'd2);
      rd_chk("lvl_claim", 12'h008, 32'd2);
      check("lvl_irq_after_claim", 32'(cpu_irq), 32'd1);
      wr(12'h000, 32'h2);
      check("lvl_irq_after_w1c", 32'(cpu_irq), 32'd1);
      irq_src = 4'b0000;
      repeat (3) @(negedge clk);
      check("lvl_irq_off", 32'(cpu_irq), 32'd0);
      check("lvl_id_off", 32'(irq_id), 32'd0);
`else
      // Single source: edge to interrupt takes SYNC_STAGES+1 edges
      wr(12'h004, 32'h1);
      rd_chk("enable_rb", 12'h004, 32'h1);
      irq_src[0] = 1'b1;
      @(negedge clk);
      check("src0_lat1", 32'(cpu_irq), 32'd0);
      @(negedge clk);
      check("src0_lat2", 32'(cpu_irq), 32'd0);
      @(negedge clk);
      check("src0_irq", 32'(cpu_irq), 32'd1);
      check("src0_id", 32'(irq_id), 32'd1);
      irq_src[0] = 1'b0;
      rd_chk("pending_src0", 12'h000, 32'h1);
      wr(12'h000, 32'h1);
      check("w1c_irq_off", 32'(cpu_irq), 32'd0);
      rd_chk("pending_cleared", 12'h000, 32'h0);

      // Priority and claim sequence; source 1 pending but masked
      wr(12'h004, 32'h5);
      irq_src = 4'b0111;
      repeat (3) @(negedge clk);
      irq_src = 4'b0000;
      repeat (3) @(negedge clk);
      check("prio_irq", 32'(cpu_irq), 32'd1);
      check("prio_id", 32'(irq_id), 32'd1);
      rd_chk("claim_1", 12'h008, 32'd1);
      check("id_after_claim1", 32'(irq_id), 32'd3);
      rd_chk("claim_2", 12'h008, 32'd3);
      rd_chk("claim_3", 12'h008, 32'd0);
      check("claim_irq_off", 32'(cpu_irq), 32'd0);
      check("claim_id_off", 32'(irq_id), 32'd0);
      rd_chk("pending_masked", 12'h000, 32'h2);
      wr(12'h000, 32'h2);
      rd_chk("pending_empty", 12'h000, 32'h0);

      // Set edge on source 2 coincides with a W1C of bit 2
      irq_src[2] = 1'b1;
      repeat (3) @(negedge clk);
      irq_src[2] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_id3", 32'(irq_id), 32'd3);
      irq_src[2] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 12'h000;
      req_wdata = 32'h4;
      @(negedge clk);
      req_valid = 1'b0;
      check("race_resp_valid", 32'(resp_valid), 32'd1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("race_irq", 32'(cpu_irq), 32'd1);
      rd_chk("race_pending", 12'h000, 32'h4);
      irq_src[2] = 1'b0;
      wr(12'h000, 32'h4);
      rd_chk("w1c_plain", 12'h000, 32'h0);

      // Response back-pressure
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h004;
      @(negedge clk);
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp_resp_valid", 32'(resp_valid), 32'd1);
         check("bp_resp_rdata", resp_rdata, 32'h5);
         check("bp_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("bp_released", 32'(req_ready), 32'd1);

      // Unmapped offset and ignored low address bits
      rd_chk("unmapped_rd", 12'h010, 32'h0);
      wr(12'h010, 32'hFFFF_FFFF);
      rd_chk("unmapped_no_enable", 12'h004, 32'h5);
      rd_chk("unmapped_no_pend", 12'h000, 32'h0);
      rd_chk("addr_low_bits", 12'h006, 32'h5);

      // RAW shows synchronized lines
      irq_src = 4'b0010;
      repeat (3) @(negedge clk);
      rd_chk("raw", 12'h00C, 32'h2);
      irq_src = 4'b0000;

      // Reset while a response is outstanding
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 12'h004;
      @(negedge clk);
      req_valid = 1'b0;
      check("rr_resp_valid", 32'(resp_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rr_resp_dropped", 32'(resp_valid), 32'd0);
      check("rr_req_ready", 32'(req_ready), 32'd1);
      check("rr_rdata", resp_rdata, 32'd0);
      rst = 1'b0;
      rd_chk("rr_enable", 12'h004, 32'h0);
      rd_chk("rr_pending", 12'h000, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
